hist_peak_finder: RTL and testbench

- Downstream stage of the dTOF histogram accumulator.
- After an acquisition set finishes, it scans one pixel's completed histogram through a 1-cycle-latency read port and finds the peak bin (maximum count, lowest address on ties).
- It reports the result with a valid/ready handshake, tagged as coarse (CH) or fine (FH) histogram per his_num.
- The result feeds the coarse/fine time-of-flight reconstruction.

---
 rtl/hist_peak_finder.sv | 163 ++++++++++++++++
 tb/tb_hist_peak_finder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_peak_finder.sv
// Peak-bin finder for one pixel's completed dTOF histogram (coarse or fine).
// Optional ambient-floor rejection is compiled in with `define FLOOR_REJECT_EN.
module hist_peak_finder #(
  parameter int unsigned NB        = 4,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned FLOOR_THR = 2
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic                  his_num,
  input  logic [PIX_W-1:0]      pix_idx,
  output logic                  busy,
  output logic                  rd_en,
  output logic [PIX_W+NB-1:0]   rd_addr,
  input  logic [CNT_W-1:0]      rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NB-1:0]         peak_addr,
  output logic [CNT_W-1:0]      peak_count,
  output logic [PIX_W-1:0]      peak_pix,
  output logic                  peak_is_fh,
`ifdef FLOOR_REJECT_EN
  output logic [CNT_W-1:0]      floor_count,
`endif
  output logic                  hist_empty
);

  if (FLOOR_THR > 2**CNT_W) begin : g_thr_check
    $error("FLOOR_THR exceeds the representable count range");
  end

  localparam logic [NB-1:0] BIN_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [PIX_W-1:0] pix_r;
  logic             fh_r;
  logic [NB-1:0]    bin;
  logic [NB-1:0]    bin_d;
  logic             rd_vld_d;
  logic [CNT_W-1:0] run_max, max_nxt;
  logic [NB-1:0]    run_addr, addr_nxt;
  logic             empty_nxt;

`ifdef FLOOR_REJECT_EN
  localparam logic [CNT_W:0] THR = (CNT_W+1)'(FLOOR_THR);
  logic [CNT_W-1:0] run_min, min_nxt;
  logic [CNT_W:0]   margin;
`endif

  always_ff @(posedge clk) begin
    if (res) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  if (bin == BIN_LAST) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_en     = (state == S_SCAN);
  assign rd_addr   = rd_en ? {pix_r, bin} : '0;
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  // Strict greater-than keeps the earliest (lowest) bin on equal counts.
  always_comb begin
    max_nxt  = run_max;
    addr_nxt = run_addr;
    if (rd_vld_d && (rd_data > run_max)) begin
      max_nxt  = rd_data;
      addr_nxt = bin_d;
    end
  end

`ifdef FLOOR_REJECT_EN
  always_comb begin
    min_nxt = run_min;
    if (rd_vld_d && (rd_data < run_min)) min_nxt = rd_data;
    margin    = {1'b0, max_nxt - min_nxt};
    empty_nxt = (max_nxt == '0) || (margin < THR);
  end
`else
  assign empty_nxt = (max_nxt == '0);
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      pix_r      <= '0;
      fh_r       <= 1'b0;
      bin        <= '0;
      bin_d      <= '0;
      rd_vld_d   <= 1'b0;
      run_max    <= '0;
      run_addr   <= '0;
      peak_addr  <= '0;
      peak_count <= '0;
      peak_pix   <= '0;
      peak_is_fh <= 1'b0;
      hist_empty <= 1'b0;
`ifdef FLOOR_REJECT_EN
      run_min     <= '1;
      floor_count <= '0;
`endif
    end else begin
      rd_vld_d <= rd_en;
      bin_d    <= bin;
      case (state)
        S_IDLE: begin
          if (start) begin
            pix_r    <= pix_idx;
            fh_r     <= his_num;
            bin      <= '0;
            run_max  <= '0;
            run_addr <= '0;
`ifdef FLOOR_REJECT_EN
            run_min  <= '1;
`endif
          end
        end
        S_SCAN: begin
          bin      <= bin + 1'b1;
          run_max  <= max_nxt;
          run_addr <= addr_nxt;
`ifdef FLOOR_REJECT_EN
          run_min  <= min_nxt;
`endif
        end
        S_DRAIN: begin
          // The last bin's data arrives in this cycle, so results take the bypassed values.
          run_max    <= max_nxt;
          run_addr   <= addr_nxt;
          peak_addr  <= addr_nxt;
          peak_count <= max_nxt;
          peak_pix   <= pix_r;
          peak_is_fh <= fh_r;
          hist_empty <= empty_nxt;
`ifdef FLOOR_REJECT_EN
          run_min     <= min_nxt;
          floor_count <= min_nxt;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_peak_finder.sv
// Self-checking bench for hist_peak_finder: histogram memory model, transaction-level
// reference model, per-cycle compare and directed literal checks.
module tb_hist_peak_finder;
  localparam int NB = 4, PIX_W = 8, CNT_W = 8, FLOOR_THR = 2;
  localparam int BIN_NUM = 16;
  localparam int LAT = BIN_NUM + 1;

  logic                clk = 1'b0;
  logic                res, start, his_num, out_ready;
  logic [PIX_W-1:0]    pix_idx;
  logic                busy, rd_en, out_valid, peak_is_fh, hist_empty;
  logic [PIX_W+NB-1:0] rd_addr;
  logic [CNT_W-1:0]    rd_data = '0;
  logic [NB-1:0]       peak_addr;
  logic [CNT_W-1:0]    peak_count;
  logic [PIX_W-1:0]    peak_pix;
`ifdef FLOOR_REJECT_EN
  logic [CNT_W-1:0]    floor_count;
`endif

  hist_peak_finder #(.NB(NB), .PIX_W(PIX_W), .CNT_W(CNT_W), .FLOOR_THR(FLOOR_THR)) dut (
    .clk(clk), .res(res), .start(start), .his_num(his_num), .pix_idx(pix_idx),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .peak_addr(peak_addr),
    .peak_count(peak_count), .peak_pix(peak_pix), .peak_is_fh(peak_is_fh),
`ifdef FLOOR_REJECT_EN
    .floor_count(floor_count),
`endif
    .hist_empty(hist_empty)
  );

  always #5 clk = ~clk;

  logic [CNT_W-1:0] mem [0:4095];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction timeline plus peak computed straight from memory.
  bit m_busy = 0, m_valid = 0, m_fh = 0;
  int m_t = 0, m_pix = 0;
  int e_addr = 0, e_count = 0, e_pix = 0, e_floor = 0;
  bit e_fh = 0, e_empty = 0;

  always @(posedge clk) begin
    if (res) begin
      m_busy = 0; m_valid = 0; m_t = 0;
      e_addr = 0; e_count = 0; e_pix = 0; e_fh = 0; e_empty = 0; e_floor = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_t = 0; m_pix = pix_idx; m_fh = his_num;
      end
    end else if (m_valid) begin
      if (out_ready) begin m_busy = 0; m_valid = 0; end
    end else begin
      m_t++;
      if (m_t == LAT) begin
        int mx, mn, ad, v;
        mx = 0; mn = 255; ad = 0;
        for (int b = 0; b < BIN_NUM; b++) begin
          v = mem[m_pix*BIN_NUM + b];
          if (v > mx) begin mx = v; ad = b; end
          if (v < mn) mn = v;
        end
        e_addr = ad; e_count = mx; e_pix = m_pix; e_fh = m_fh;
        e_empty = (mx == 0);
`ifdef FLOOR_REJECT_EN
        if (mx - mn < FLOOR_THR) e_empty = 1;
        e_floor = mn;
`endif
        m_valid = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit er;
    er = m_busy && !m_valid && (m_t < BIN_NUM);
    chk("busy", busy, m_busy);
    chk("rd_en", rd_en, er);
    chk("rd_addr", rd_addr, er ? m_pix*BIN_NUM + m_t : 0);
    chk("out_valid", out_valid, m_valid);
    chk("peak_addr", peak_addr, e_addr);
    chk("peak_count", peak_count, e_count);
    chk("peak_pix", peak_pix, e_pix);
    chk("peak_is_fh", peak_is_fh, e_fh);
    chk("hist_empty", hist_empty, e_empty);
`ifdef FLOOR_REJECT_EN
    chk("floor_count", floor_count, e_floor);
`endif
  end

  int lat, first_addr;
  int g_addr, g_count, g_pix, g_fh, g_empty, g_floor;

  task automatic fill(input int pix, input int base);
    for (int b = 0; b < BIN_NUM; b++) mem[pix*BIN_NUM + b] = CNT_W'(base);
  endtask

  task automatic run(input int pix, input bit fh, input int hold);
    int n;
    @(posedge clk); #1;
    start = 1; pix_idx = PIX_W'(pix); his_num = fh; out_ready = (hold == 0);
    @(posedge clk); #1;
    start = 0; pix_idx = PIX_W'($urandom); his_num = 1'($urandom);
    @(negedge clk);
    first_addr = rd_addr;
    lat = 0;
    while (1) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid || lat > 3*LAT) break;
    end
    chk("latency", lat, LAT);
    g_addr = peak_addr; g_count = peak_count; g_pix = peak_pix;
    g_fh = peak_is_fh; g_empty = hist_empty;
`ifdef FLOOR_REJECT_EN
    g_floor = floor_count;
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      start = (i == 1) ? 1'b1 : 1'($urandom);
      pix_idx = PIX_W'($urandom);
      @(negedge clk);
      chk("hold_busy", busy, 1);
      chk("hold_count", peak_count, g_count);
    end
    @(posedge clk); #1;
    start = 0; out_ready = 1;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (!busy || n > 10) break;
    end
    chk("release_busy", busy, 0);
    chk("release_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1; start = 0; his_num = 0; out_ready = 1; pix_idx = '0;
    for (int i = 0; i < 4096; i++) mem[i] = CNT_W'($urandom);

    @(posedge clk); @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_peak_count", peak_count, 0);
    @(posedge clk); #1 res = 0;

    // Basic peak: pixel 3, bin 5 = 40, others 1.
    fill(3, 1); mem[3*BIN_NUM + 5] = 40;
    run(3, 0, 0);
    chk("t1_first_addr", first_addr, 48);
    chk("t1_addr", g_addr, 5);
    chk("t1_count", g_count, 40);
    chk("t1_pix", g_pix, 3);
    chk("t1_fh", g_fh, 0);
    chk("t1_empty", g_empty, 0);

    // Tie: lowest address wins.
    fill(10, 0); mem[10*BIN_NUM + 2] = 7; mem[10*BIN_NUM + 9] = 7;
    run(10, 0, 0);
    chk("tie_addr", g_addr, 2);
    chk("tie_count", g_count, 7);

    // All zero, fine histogram.
    fill(20, 0);
    run(20, 1, 0);
    chk("zero_empty", g_empty, 1);
    chk("zero_addr", g_addr, 0);
    chk("zero_count", g_count, 0);
    chk("zero_fh", g_fh, 1);

    // Backpressure with an ignored start during the wait.
    run(3, 0, 5);
    chk("bp_addr", g_addr, 5);
    chk("bp_count", peak_count, 40);

    // Reset at edge 8 after start aborts the scan.
    fill(5, 3); mem[5*BIN_NUM + 12] = 99;
    @(posedge clk); #1 start = 1; pix_idx = 8'd5; his_num = 0;
    @(posedge clk); #1 start = 0;
    repeat (7) @(posedge clk);
    #1 res = 1;
    @(posedge clk); #1 res = 0;
    @(negedge clk);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    run(5, 0, 1);
    chk("abort_rerun_addr", g_addr, 12);
    chk("abort_rerun_count", g_count, 99);

`ifdef FLOOR_REJECT_EN
    fill(30, 10); mem[30*BIN_NUM + 4] = 11;
    run(30, 0, 0);
    chk("floor_rej_empty", g_empty, 1);
    chk("floor_rej_addr", g_addr, 4);
    chk("floor_rej_floor", g_floor, 10);
    mem[30*BIN_NUM + 4] = 12;
    run(30, 0, 0);
    chk("floor_ok_empty", g_empty, 0);
    chk("floor_ok_addr", g_addr, 4);
`endif

    // Randomized histograms of varied shape.
    for (int it = 0; it < 30; it++) begin
      int pix, kind;
      pix  = $urandom_range(0, 255);
      kind = $urandom_range(0, 3);
      for (int b = 0; b < BIN_NUM; b++) begin
        case (kind)
          0: mem[pix*BIN_NUM + b] = CNT_W'($urandom);
          1: mem[pix*BIN_NUM + b] = CNT_W'($urandom_range(0, 3));
          2: mem[pix*BIN_NUM + b] = '0;
          default: mem[pix*BIN_NUM + b] = 8'd10;
        endcase
      end
      if (kind == 3) mem[pix*BIN_NUM + $urandom_range(0, 15)] = CNT_W'($urandom_range(10, 14));
      run(pix, 1'($urandom), $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
